// File: rtl/simple_bus_responder.sv
// simple_bus target: single-beat read/write into a DEPTH-word register
// file, one response per accepted request after LAT wait cycles.
// Ports: clk, rst_n; req_valid/req_ready/req_write/req_addr/req_wdata;
// rsp_valid/rsp_ready/rsp_rdata/rsp_err (+ rsp_par when
// SIMPLE_BUS_RSP_PARITY_EN is defined).
module simple_bus_responder #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 12,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
`ifdef SIMPLE_BUS_RSP_PARITY_EN
  output logic          rsp_par,
`endif
  output logic          rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [3:0]  CNT_LD  = 4'(LAT > 0 ? LAT - 1 : 0);

  state_t        state;
  state_t        nxt;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic          rdy_q;
  logic          vld_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [DW-1:0] rf [DEPTH];
`ifdef SIMPLE_BUS_RSP_PARITY_EN
  logic          rf_par [DEPTH];
`endif

  logic          acc;
  logic          done;
  logic          enter_resp;
  logic          req_in_rng;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic          sel_in_rng;
  logic          par_bad;

  assign acc        = (state == IDLE) & req_valid & rdy_q;
  assign done       = vld_q & rsp_ready;
  assign enter_resp = (state != RESP) & (nxt == RESP);
  assign req_in_rng = {1'b0, req_addr} < DEPTH_W;

  // With LAT=0 RESP is entered on the accept edge itself, before the
  // request fields are latched, so take them straight from the bus.
  assign sel_wr     = (state == IDLE) ? req_write : wr_q;
  assign sel_addr   = (state == IDLE) ? req_addr  : addr_q;
  assign sel_in_rng = {1'b0, sel_addr} < DEPTH_W;

`ifdef SIMPLE_BUS_RSP_PARITY_EN
  assign par_bad = sel_in_rng & ~sel_wr &
                   (rf_par[sel_addr] != ^rf[sel_addr]);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
`ifdef SIMPLE_BUS_RSP_PARITY_EN
        rf_par[i] <= 1'b0;
`endif
      end
    end else begin
      state <= nxt;
      rdy_q <= (nxt == IDLE);
      // Response is presented one cycle after RESP is entered, which
      // gives accept-to-valid of LAT+1 edges.
      vld_q <= (state == RESP) & (nxt == RESP);
      if (acc) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        cnt    <= CNT_LD;
        if (req_write && req_in_rng) begin
          rf[req_addr] <= req_wdata;
`ifdef SIMPLE_BUS_RSP_PARITY_EN
          rf_par[req_addr] <= ^req_wdata;
`endif
        end
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (!sel_wr && sel_in_rng) ? rf[sel_addr] : '0;
        err_q   <= ~sel_in_rng | par_bad;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = (LAT > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'd0) nxt = RESP;
      RESP: if (done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rdy_q;
    rsp_valid = vld_q;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
`ifdef SIMPLE_BUS_RSP_PARITY_EN
    rsp_par   = ^rdata_q;
`endif
  end

endmodule

// File: tb/tb_simple_bus_responder.sv
// Bench for simple_bus_responder: cycle model plus directed
// transactions with literal expectations.
module tb_simple_bus_responder;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
`ifdef SIMPLE_BUS_RSP_PARITY_EN
  logic          rsp_par;
  logic          last_par;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  simple_bus_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
`ifdef SIMPLE_BUS_RSP_PARITY_EN
    .rsp_par(rsp_par),
`endif
    .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding request, response due
  // LAT+1 edges after the accept edge.
  bit            run = 1'b0;
  int            cyc = 0;
  logic          m_ready;
  logic          m_pend;
  int            m_due;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd;
  logic          m_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic ev;
    logic in;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_pend  = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (run) begin
      ev = m_pend && (cyc >= m_due);
      chk("req_ready", req_ready, m_ready);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", rsp_err, m_err);
`ifdef SIMPLE_BUS_RSP_PARITY_EN
        chk("rsp_par", rsp_par, ^m_rd);
`endif
      end
      if (ev && rsp_ready) begin
        m_pend  = 1'b0;
        m_ready = 1'b1;
      end else if (m_ready && req_valid) begin
        m_ready = 1'b0;
        m_pend  = 1'b1;
        m_due   = cyc + 2 + LAT;
        in      = int'(req_addr) < DEPTH;
        m_err   = !in;
        if (req_write) begin
          if (in) m_mem[req_addr] = req_wdata;
          m_rd = '0;
        end else begin
          m_rd = in ? m_mem[req_addr] : '0;
        end
      end else if (!m_ready && !m_pend) begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", n < 50, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_bound", lat < 50, 1);
  endtask

  task automatic txn(input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output logic er,
                     output int lat);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_accept();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
`ifdef SIMPLE_BUS_RSP_PARITY_EN
    last_par = rsp_par;
`endif
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] rd;
  logic [DW-1:0] hold;
  logic          er;
  int            lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(0, 4'd3, '0, rd, er, lat);
    chk("rd3_data", rd, 0);
    chk("rd3_err", er, 0);
    chk("rd3_latency", lat, 3);

    txn(1, 4'd5, 32'hDEADBEEF, rd, er, lat);
    chk("wr5_data", rd, 0);
    chk("wr5_err", er, 0);
    txn(0, 4'd5, '0, rd, er, lat);
    chk("rd5_data", rd, 32'hDEADBEEF);
    chk("rd5_err", er, 0);

    txn(1, 4'd13, 32'h1234, rd, er, lat);
    chk("wr13_data", rd, 0);
    chk("wr13_err", er, 1);
    txn(0, 4'd13, '0, rd, er, lat);
    chk("rd13_data", rd, 0);
    chk("rd13_err", er, 1);
    for (int i = 0; i < DEPTH; i++) begin
      txn(0, AW'(i), '0, rd, er, lat);
      chk($sformatf("sweep%0d", i), {rd, 31'b0, er},
          {(i == 5) ? 32'hDEADBEEF : 32'h0, 32'h0});
    end
    txn(0, 4'd12, '0, rd, er, lat);
    chk("rd12_err", er, 1);
    txn(0, 4'd15, '0, rd, er, lat);
    chk("rd15_err", {rd, 31'b0, er}, 64'h1);

    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    wait_accept();
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 32'h0BADF00D;
    wait_rsp(lat);
    hold = rsp_rdata;
    chk("bp_data", hold, 32'hDEADBEEF);
    repeat (10) @(negedge clk);
    chk("bp_valid_held", rsp_valid, 1);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_data_stable", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rearm", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp_wr_err", rsp_err, 0);
    @(posedge clk);
    #1;
    txn(0, 4'd2, '0, rd, er, lat);
    chk("rd2_data", rd, 32'h0BADF00D);

    txn(1, 4'd1, 32'hA5, rd, er, lat);
    txn(0, 4'd1, '0, rd, er, lat);
    chk("rd1_data", rd, 32'hA5);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd1;
    wait_accept();
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_err", rsp_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    txn(0, 4'd1, '0, rd, er, lat);
    chk("post_rst_rd1", rd, 0);
    txn(0, 4'd5, '0, rd, er, lat);
    chk("post_rst_rd5", rd, 0);

`ifdef SIMPLE_BUS_RSP_PARITY_EN
    txn(1, 4'd9, 32'h7, rd, er, lat);
    txn(0, 4'd9, '0, rd, er, lat);
    chk("par7_data", rd, 32'h7);
    chk("par7_par", last_par, 1);
    chk("par7_err", er, 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
